controle_medicoes_faixa: RTL and testbench

- Scheduler/controller that sequences the ultrasonic interface (interface_hcsr04) and serial transmitter inside medidor_faixa.
- Issues periodic one-cycle `medir` pulses, waits for the measurement or a timeout, and compares the BCD distance against [lowerL, upperL].
- Requests a serial transmission of each valid measurement.
- Asserts `acertou` after N_ACERTOS consecutive in-range measurements.

---
 rtl/controle_medicoes_faixa.sv | 238 +++++++++++++++++++++++
 tb/tb_controle_medicoes_faixa.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/controle_medicoes_faixa.sv
// controle_medicoes_faixa
//
// Scheduler for the medidor_faixa distance gauge. It fires a one-cycle `medir`
// pulse at the ultrasonic interface, waits for `pronto` or a timeout, checks the
// BCD distance against [lowerL, upperL], asks the serial transmitter to send the
// result, and raises `acertou` after N_ACERTOS consecutive in-range readings.
//
// Optional build macro: TIMEOUT_RETRY_EN
//   When defined, the first timeout of a measurement cycle re-issues `medir` at
//   once without touching falha or the hit count. A second consecutive timeout
//   is handled as a normal timeout.
//
// Parameters
//   INTERVALO  idle cycles between the end of one cycle and the next medir (>= 2)
//   TIMEOUT    max cycles waiting for pronto (>= 2)
//   N_ACERTOS  consecutive in-range hits needed for acertou (1..15)
//
// Ports
//   clock       system clock
//   reset       asynchronous, active-high reset
//   ligar       level, 1 = run the measurement loop, 0 = return to INICIAL
//   pronto      one-cycle pulse, medida valid
//   medida      3-digit BCD distance in cm
//   upperL      BCD upper limit, inclusive
//   lowerL      BCD lower limit, inclusive
//   tx_pronto   one-cycle pulse, serial frame sent
//   medir       one-cycle pulse to start a measurement
//   transmitir  one-cycle pulse to start a serial frame
//   dentro      result of the last completed comparison
//   acertou     goal reached (held until ligar drops)
//   falha       last measurement timed out
//   db_acertos  current consecutive-hit count
//   db_estado   state code
module controle_medicoes_faixa #(
    parameter int unsigned INTERVALO = 2_500_000,
    parameter int unsigned TIMEOUT   = 1_500_000,
    parameter int unsigned N_ACERTOS = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ligar,
    input  logic        pronto,
    input  logic [11:0] medida,
    input  logic [11:0] upperL,
    input  logic [11:0] lowerL,
    input  logic        tx_pronto,
    output logic        medir,
    output logic        transmitir,
    output logic        dentro,
    output logic        acertou,
    output logic        falha,
    output logic [3:0]  db_acertos,
    output logic [3:0]  db_estado
);

    localparam int unsigned LarguraTimeout   = $clog2(TIMEOUT);
    localparam int unsigned LarguraIntervalo = $clog2(INTERVALO);
    localparam logic [LarguraTimeout-1:0]   TimeoutMax   = LarguraTimeout'(TIMEOUT - 1);
    localparam logic [LarguraIntervalo-1:0] IntervaloMax = LarguraIntervalo'(INTERVALO - 1);
    localparam logic [3:0]                  AcertosAlvo  = 4'(N_ACERTOS);

    typedef enum logic [2:0] {
        StInicial   = 3'd0,
        StPrepara   = 3'd1,
        StMedir     = 3'd2,
        StAguarda   = 3'd3,
        StCompara   = 3'd4,
        StTransmite = 3'd5,
        StIntervalo = 3'd6,
        StAcertou   = 3'd7
    } estado_t;

    estado_t                     estado_q, estado_d;
    logic [LarguraTimeout-1:0]   cnt_timeout_q, cnt_timeout_d;
    logic [LarguraIntervalo-1:0] cnt_intervalo_q, cnt_intervalo_d;
    logic [11:0]                 medida_q, medida_d;
    logic                        dentro_q, dentro_d;
    logic                        falha_q, falha_d;
    logic                        acertou_q, acertou_d;
    logic [3:0]                  acertos_q, acertos_d;
    logic                        tx_feito_q, tx_feito_d;
`ifdef TIMEOUT_RETRY_EN
    logic                        retry_q, retry_d;
`endif

    logic bcd_valido;
    logic na_faixa;

    // Packed BCD orders like binary only when every digit is 0..9.
    assign bcd_valido = (medida_q[3:0] <= 4'd9) && (medida_q[7:4] <= 4'd9) &&
                        (medida_q[11:8] <= 4'd9);
    assign na_faixa   = bcd_valido && (lowerL <= medida_q) && (medida_q <= upperL);

    always_comb begin
        estado_d        = estado_q;
        cnt_timeout_d   = cnt_timeout_q;
        cnt_intervalo_d = '0;
        medida_d        = medida_q;
        dentro_d        = dentro_q;
        falha_d         = falha_q;
        acertou_d       = acertou_q;
        acertos_d       = acertos_q;
        tx_feito_d      = 1'b0;
`ifdef TIMEOUT_RETRY_EN
        retry_d         = retry_q;
`endif
        medir           = 1'b0;
        transmitir      = 1'b0;

        // A frame in flight is always allowed to complete before stopping.
        if (!ligar && (estado_q != StTransmite)) begin
            estado_d = StInicial;
        end else begin
            unique case (estado_q)
                StInicial: begin
                    if (ligar) estado_d = StPrepara;
                end
                StPrepara: begin
                    acertos_d = '0;
                    falha_d   = 1'b0;
                    dentro_d  = 1'b0;
`ifdef TIMEOUT_RETRY_EN
                    retry_d   = 1'b0;
`endif
                    estado_d  = StMedir;
                end
                StMedir: begin
                    medir         = 1'b1;
                    cnt_timeout_d = '0;
                    estado_d      = StAguarda;
                end
                StAguarda: begin
                    cnt_timeout_d = cnt_timeout_q + 1'b1;
                    if (pronto) begin
                        // pronto takes priority even on the timeout cycle
                        medida_d = medida;
                        estado_d = StCompara;
                    end else if (cnt_timeout_q == TimeoutMax) begin
`ifdef TIMEOUT_RETRY_EN
                        if (!retry_q) begin
                            retry_d  = 1'b1;
                            estado_d = StMedir;
                        end else begin
                            retry_d   = 1'b0;
                            falha_d   = 1'b1;
                            acertos_d = '0;
                            dentro_d  = 1'b0;
                            estado_d  = StIntervalo;
                        end
`else
                        falha_d   = 1'b1;
                        acertos_d = '0;
                        dentro_d  = 1'b0;
                        estado_d  = StIntervalo;
`endif
                    end
                end
                StCompara: begin
                    falha_d  = 1'b0;
                    dentro_d = na_faixa;
                    if (na_faixa) begin
                        acertos_d = (acertos_q == 4'hF) ? 4'hF : acertos_q + 4'd1;
                    end else begin
                        acertos_d = '0;
                    end
`ifdef TIMEOUT_RETRY_EN
                    retry_d  = 1'b0;
`endif
                    estado_d = StTransmite;
                end
                StTransmite: begin
                    transmitir = !tx_feito_q;
                    tx_feito_d = 1'b1;
                    if (tx_pronto) begin
                        if (!ligar) begin
                            estado_d = StInicial;
                        end else if (acertos_q == AcertosAlvo) begin
                            acertou_d = 1'b1;
                            estado_d  = StAcertou;
                        end else begin
                            estado_d = StIntervalo;
                        end
                    end
                end
                StIntervalo: begin
                    if (cnt_intervalo_q == IntervaloMax) begin
                        estado_d = StMedir;
                    end else begin
                        cnt_intervalo_d = cnt_intervalo_q + 1'b1;
                    end
                end
                StAcertou: begin
                    // Parked until ligar drops.
                end
                default: estado_d = StInicial;
            endcase
        end

        if (estado_d == StInicial) acertou_d = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q        <= StInicial;
            cnt_timeout_q   <= '0;
            cnt_intervalo_q <= '0;
            medida_q        <= '0;
            dentro_q        <= 1'b0;
            falha_q         <= 1'b0;
            acertou_q       <= 1'b0;
            acertos_q       <= '0;
            tx_feito_q      <= 1'b0;
`ifdef TIMEOUT_RETRY_EN
            retry_q         <= 1'b0;
`endif
        end else begin
            estado_q        <= estado_d;
            cnt_timeout_q   <= cnt_timeout_d;
            cnt_intervalo_q <= cnt_intervalo_d;
            medida_q        <= medida_d;
            dentro_q        <= dentro_d;
            falha_q         <= falha_d;
            acertou_q       <= acertou_d;
            acertos_q       <= acertos_d;
            tx_feito_q      <= tx_feito_d;
`ifdef TIMEOUT_RETRY_EN
            retry_q         <= retry_d;
`endif
        end
    end

    assign dentro     = dentro_q;
    assign falha      = falha_q;
    assign acertou    = acertou_q;
    assign db_acertos = acertos_q;
    assign db_estado  = {1'b0, estado_q};

endmodule

// File: tb/tb_controle_medicoes_faixa.sv
// Directed bench for controle_medicoes_faixa with INTERVALO=100, TIMEOUT=200,
// N_ACERTOS=3 and limits [0x070, 0x080]. Inputs are driven and outputs sampled
// on the falling clock edge.
module tb_controle_medicoes_faixa;

    localparam int unsigned INTERVALO = 100;
    localparam int unsigned TIMEOUT   = 200;
    localparam int unsigned N_ACERTOS = 3;

    logic        clock = 1'b0;
    logic        reset;
    logic        ligar;
    logic        pronto;
    logic [11:0] medida;
    logic [11:0] upperL;
    logic [11:0] lowerL;
    logic        tx_pronto;
    logic        medir;
    logic        transmitir;
    logic        dentro;
    logic        acertou;
    logic        falha;
    logic [3:0]  db_acertos;
    logic [3:0]  db_estado;

    int n_checks = 0;
    int n_fail   = 0;

    controle_medicoes_faixa #(
        .INTERVALO (INTERVALO),
        .TIMEOUT   (TIMEOUT),
        .N_ACERTOS (N_ACERTOS)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .ligar      (ligar),
        .pronto     (pronto),
        .medida     (medida),
        .upperL     (upperL),
        .lowerL     (lowerL),
        .tx_pronto  (tx_pronto),
        .medir      (medir),
        .transmitir (transmitir),
        .dentro     (dentro),
        .acertou    (acertou),
        .falha      (falha),
        .db_acertos (db_acertos),
        .db_estado  (db_estado)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    // Cycles until medir is seen, bounded so a stuck DUT still reaches the summary.
    task automatic wait_medir(output int n);
        n = 0;
        while ((medir !== 1'b1) && (n < 1000)) begin
            tick();
            n++;
        end
    endtask

    // Starts in MEDIR; returns in the first TRANSMITE cycle.
    task automatic measure(input logic [11:0] v, input int atraso);
        tick();
        repeat (atraso) tick();
        pronto = 1'b1;
        medida = v;
        tick();
        pronto = 1'b0;
        tick();
    endtask

    task automatic pulse_tx();
        tx_pronto = 1'b1;
        tick();
        tx_pronto = 1'b0;
    endtask

    initial begin
        int n;
        logic saw;

        reset     = 1'b1;
        ligar     = 1'b0;
        pronto    = 1'b0;
        tx_pronto = 1'b0;
        medida    = 12'h000;
        lowerL    = 12'h070;
        upperL    = 12'h080;
        tick();
        tick();
        check("rst_estado", int'(db_estado), 0);
        check("rst_medir", int'(medir), 0);
        check("rst_transmitir", int'(transmitir), 0);
        check("rst_dentro", int'(dentro), 0);
        check("rst_acertou", int'(acertou), 0);
        check("rst_falha", int'(falha), 0);
        check("rst_acertos", int'(db_acertos), 0);
        reset = 1'b0;
        tick();
        check("idle_inicial", int'(db_estado), 0);

        // First measurement and its timing
        ligar = 1'b1;
        wait_medir(n);
        check("lat_ligar_medir", n, 2);
        measure(12'h075, 48);
        check("m1_estado", int'(db_estado), 5);
        check("m1_transmitir", int'(transmitir), 1);
        check("m1_dentro", int'(dentro), 1);
        check("m1_acertos", int'(db_acertos), 1);
        check("m1_falha", int'(falha), 0);
        tick();
        check("m1_tx_unico", int'(transmitir), 0);
        check("m1_espera_tx", int'(db_estado), 5);
        pulse_tx();
        check("m1_intervalo", int'(db_estado), 6);
        wait_medir(n);
        check("m1_intervalo_len", n, 100);

        // Three consecutive hits reach the goal
        measure(12'h075, 10);
        check("m2_acertos", int'(db_acertos), 2);
        pulse_tx();
        wait_medir(n);
        check("m2_intervalo_len", n, 100);
        measure(12'h075, 10);
        check("m3_acertos", int'(db_acertos), 3);
        pulse_tx();
        check("acertou_set", int'(acertou), 1);
        check("acertou_estado", int'(db_estado), 7);
        saw = 1'b0;
        repeat (300) begin
            tick();
            if (medir === 1'b1) saw = 1'b1;
        end
        check("acertou_sem_medir", int'(saw), 0);
        check("acertou_mantido", int'(acertou), 1);
        ligar = 1'b0;
        tick();
        check("desl_acertou", int'(acertou), 0);
        check("desl_estado", int'(db_estado), 0);
        check("desl_hold_acertos", int'(db_acertos), 3);
        check("desl_hold_dentro", int'(dentro), 1);

        // Hit count sequence, boundaries, invalid BCD
        ligar = 1'b1;
        wait_medir(n);
        check("relig_lat", n, 2);
        measure(12'h075, 5);
        check("s075_acertos", int'(db_acertos), 1);
        pulse_tx();
        wait_medir(n);
        measure(12'h100, 5);
        check("s100_dentro", int'(dentro), 0);
        check("s100_acertos", int'(db_acertos), 0);
        pulse_tx();
        wait_medir(n);
        measure(12'h074, 5);
        check("s074_dentro", int'(dentro), 1);
        check("s074_acertos", int'(db_acertos), 1);
        pulse_tx();
        wait_medir(n);
        measure(12'h070, 5);
        check("s070_dentro", int'(dentro), 1);
        check("s070_acertos", int'(db_acertos), 2);
        pulse_tx();
        wait_medir(n);
        measure(12'h07A, 5);
        check("s07a_dentro", int'(dentro), 0);
        check("s07a_acertos", int'(db_acertos), 0);
        pulse_tx();
        wait_medir(n);
        measure(12'h080, 5);
        check("s080_dentro", int'(dentro), 1);
        check("s080_acertos", int'(db_acertos), 1);
        pulse_tx();
        wait_medir(n);
        check("s080_intervalo_len", n, 100);

        // Timeout
        tick();
        repeat (199) tick();
        check("to_ainda_aguarda", int'(db_estado), 3);
        check("to_ainda_sem_falha", int'(falha), 0);
        tick();
`ifdef TIMEOUT_RETRY_EN
        check("retry_estado", int'(db_estado), 2);
        check("retry_medir", int'(medir), 1);
        check("retry_falha", int'(falha), 0);
        check("retry_acertos", int'(db_acertos), 1);
        tick();
        repeat (199) tick();
        tick();
`endif
        check("to_estado", int'(db_estado), 6);
        check("to_falha", int'(falha), 1);
        check("to_acertos", int'(db_acertos), 0);
        check("to_dentro", int'(dentro), 0);
        check("to_transmitir", int'(transmitir), 0);
        wait_medir(n);
        check("to_intervalo_len", n, 100);

        // pronto on the exact timeout cycle wins
        measure(12'h075, 199);
        check("pt_estado", int'(db_estado), 5);
        check("pt_falha", int'(falha), 0);
        check("pt_dentro", int'(dentro), 1);
        check("pt_acertos", int'(db_acertos), 1);
        check("pt_transmitir", int'(transmitir), 1);

        // ligar drop during TRANSMITE waits for the frame
        ligar = 1'b0;
        tick();
        check("tx_desl_espera", int'(db_estado), 5);
        pulse_tx();
        check("tx_desl_inicial", int'(db_estado), 0);
        check("tx_desl_hold_dentro", int'(dentro), 1);

        // Asynchronous reset mid-AGUARDA
        ligar = 1'b1;
        wait_medir(n);
        measure(12'h075, 5);
        pulse_tx();
        wait_medir(n);
        tick();
        check("pre_rst_estado", int'(db_estado), 3);
        check("pre_rst_dentro", int'(dentro), 1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_estado", int'(db_estado), 0);
        check("arst_dentro", int'(dentro), 0);
        check("arst_acertos", int'(db_acertos), 0);
        check("arst_medir", int'(medir), 0);
        check("arst_falha", int'(falha), 0);
        check("arst_acertou", int'(acertou), 0);
        ligar = 1'b0;
        tick();
        reset = 1'b0;
        tick();

        // ligar drop during AGUARDA returns at once
        ligar = 1'b1;
        wait_medir(n);
        check("pos_rst_lat", n, 2);
        tick();
        check("ag_estado", int'(db_estado), 3);
        ligar = 1'b0;
        tick();
        check("ag_desl_estado", int'(db_estado), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
